wb_master_bridge: RTL and testbench

//  Converts the CPU's valid/ready load-store port into single Wishbone classic cycles.
//  Its master outputs feed the Wishbone interconnect's master interface (address and strobe).
//  Its ack and read-data inputs come back from that interconnect.
//  One transaction is outstanding at a time. An optional timeout terminates cycles to

---
 rtl/wb_master_bridge.sv | 184 ++++++++++++++++++
 tb/tb_wb_master_bridge.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_bridge.sv
// -----------------------------------------------------------------------------
// wb_master_bridge
//
// Purpose:
//   Converts a CPU valid/ready load-store port into single Wishbone classic
//   cycles. Only one transaction is outstanding at a time. The request is
//   registered onto the Wishbone master outputs. The bridge holds cyc/stb
//   until the interconnect acks. It then presents one response to the CPU.
//
// Optional feature (macro WB_TIMEOUT_EN):
//   When defined, a TMO_W-bit counter aborts a Wishbone cycle that has seen
//   TMO_CYCLES stb-high cycles without an ack. The response then has
//   o_rsp_err=1 and o_rsp_rdata=0. If ack and expiry fall in the same cycle,
//   the ack wins.
//   When undefined, the bridge waits for ack indefinitely and o_rsp_err is
//   always 0.
//
// Parameters:
//   DW          data width (CPU and Wishbone)
//   AW          address width
//   TMO_W       timeout counter width
//   TMO_CYCLES  stb-high cycles without ack before abort (< 2**TMO_W)
//
// Ports:
//   i_clk, i_rst                 clock; synchronous active-high reset
//   i_req_valid / o_req_ready    CPU request handshake
//   i_req_addr/we/wdata/be       CPU request payload
//   o_rsp_valid / i_rsp_ready    CPU response handshake
//   o_rsp_rdata, o_rsp_err       CPU response payload
//   o_wbm_adr/dat/sel/we         Wishbone master request outputs
//   o_wbm_cyc, o_wbm_stb         Wishbone cycle / strobe
//   i_wbm_dat, i_wbm_ack         Wishbone read data / ack from interconnect
// -----------------------------------------------------------------------------
module wb_master_bridge #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int TMO_W      = 8,
  parameter int TMO_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  // CPU request
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [AW-1:0]   i_req_addr,
  input  logic            i_req_we,
  input  logic [DW-1:0]   i_req_wdata,
  input  logic [DW/8-1:0] i_req_be,
  // CPU response
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_rdata,
  output logic            o_rsp_err,
  // Wishbone master
  output logic [AW-1:0]   o_wbm_adr,
  output logic [DW-1:0]   o_wbm_dat,
  output logic [DW/8-1:0] o_wbm_sel,
  output logic            o_wbm_we,
  output logic            o_wbm_cyc,
  output logic            o_wbm_stb,
  input  logic [DW-1:0]   i_wbm_dat,
  input  logic            i_wbm_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Counter value seen during the last allowed stb-high cycle. The first
  // stb-high cycle sees 0, so cycle N sees N-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  state_t            r_state;
  logic [AW-1:0]     r_wbm_adr;
  logic [DW-1:0]     r_wbm_dat;
  logic [DW/8-1:0]   r_wbm_sel;
  logic              r_wbm_we;
  logic              r_wbm_cyc;
  logic              r_wbm_stb;
  logic              r_rsp_valid;
  logic [DW-1:0]     r_rsp_rdata;
  logic              r_rsp_err;
  logic              w_tmo_expired;

`ifdef WB_TIMEOUT_EN
  logic [TMO_W-1:0]  r_tmo_cnt;

  // The counter counts stb-high cycles without ack. It rests at 0 outside
  // BUS, so it is already clear when the next request is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_BUS && !i_wbm_ack) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_expired = (r_tmo_cnt == TMO_LAST);
`else
  logic w_unused_tmo;
  assign w_unused_tmo  = ^TMO_LAST;
  assign w_tmo_expired = 1'b0;
`endif

  // NOTE: every register below updates with non-blocking assignments, so all
  // of them sample the same pre-edge values within this block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_wbm_adr   <= '0;
      r_wbm_dat   <= '0;
      r_wbm_sel   <= '0;
      r_wbm_we    <= 1'b0;
      r_wbm_cyc   <= 1'b0;
      r_wbm_stb   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_wbm_adr <= i_req_addr;
            r_wbm_dat <= i_req_wdata;
            r_wbm_sel <= i_req_be;
            r_wbm_we  <= i_req_we;
            r_wbm_cyc <= 1'b1;
            r_wbm_stb <= 1'b1;
            r_state   <= S_BUS;
          end
        end

        S_BUS: begin
          // Ack is checked first, so it wins over a coincident timeout.
          if (i_wbm_ack) begin
            r_rsp_rdata <= r_wbm_we ? '0 : i_wbm_dat;
            r_rsp_err   <= 1'b0;
            r_wbm_cyc   <= 1'b0;
            r_wbm_stb   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_tmo_expired) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_wbm_cyc   <= 1'b0;
            r_wbm_stb   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: o_req_ready is decoded from state rather than registered. This lets
  // the bridge accept a request in the first cycle after reset and in the
  // cycle right after a response handshake. Gating with i_rst keeps it low
  // during the reset cycle.
  assign o_req_ready = (r_state == S_IDLE) && !i_rst;

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_wbm_adr   = r_wbm_adr;
  assign o_wbm_dat   = r_wbm_dat;
  assign o_wbm_sel   = r_wbm_sel;
  assign o_wbm_we    = r_wbm_we;
  assign o_wbm_cyc   = r_wbm_cyc;
  assign o_wbm_stb   = r_wbm_stb;

endmodule

// File: tb/tb_wb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_master_bridge
//
// Purpose:
//   Self-checking bench for wb_master_bridge. Directed transactions push their
//   expected response into a queue. A monitor pops one entry and compares it
//   on every response handshake. The stimulus thread checks Wishbone-side
//   behaviour inline: strobe duration, output stability, and the effects of
//   ready and reset.
// -----------------------------------------------------------------------------
module tb_wb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 32;

  logic            clk;
  logic            rst;
  logic            i_req_valid;
  logic            o_req_ready;
  logic [AW-1:0]   i_req_addr;
  logic            i_req_we;
  logic [DW-1:0]   i_req_wdata;
  logic [DW/8-1:0] i_req_be;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_rsp_err;
  logic [AW-1:0]   o_wbm_adr;
  logic [DW-1:0]   o_wbm_dat;
  logic [DW/8-1:0] o_wbm_sel;
  logic            o_wbm_we;
  logic            o_wbm_cyc;
  logic            o_wbm_stb;
  logic [DW-1:0]   i_wbm_dat;
  logic            i_wbm_ack;

  wb_master_bridge #(
    .DW(DW), .AW(AW), .TMO_W(8), .TMO_CYCLES(255)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_we    (i_req_we),
    .i_req_wdata (i_req_wdata),
    .i_req_be    (i_req_be),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_wbm_adr   (o_wbm_adr),
    .o_wbm_dat   (o_wbm_dat),
    .o_wbm_sel   (o_wbm_sel),
    .o_wbm_we    (o_wbm_we),
    .o_wbm_cyc   (o_wbm_cyc),
    .o_wbm_stb   (o_wbm_stb),
    .i_wbm_dat   (i_wbm_dat),
    .i_wbm_ack   (i_wbm_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   n_pushed = 0;
  int   n_popped = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] rdata, input logic err);
    rsp_t e;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Response monitor: compares every handshake against the scoreboard.
  always @(negedge clk) begin
    if (!rst && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got rdata=0x%0h err=%0b with no response expected (t=%0t)",
                 o_rsp_rdata, o_rsp_err, $time);
      end else begin
        mon_e = exp_q.pop_front();
        n_popped++;
        check("rsp_rdata", o_rsp_rdata, mon_e.rdata);
        check("rsp_err",   o_rsp_err,   mon_e.err);
      end
    end
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request and let the bridge accept it. Entry and exit are both
  // at posedge+1 with the bridge in IDLE on entry and in BUS on exit.
  task automatic start_req(input logic [AW-1:0] addr, input logic we,
                           input logic [DW-1:0] wdata, input logic [DW/8-1:0] be);
    i_req_addr  = addr;
    i_req_we    = we;
    i_req_wdata = wdata;
    i_req_be    = be;
    i_req_valid = 1'b1;
    @(negedge clk);
    check("req_ready_idle", o_req_ready, 1'b1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    // Scramble the request inputs so that the bench sees any Wishbone
    // output that follows the CPU port combinationally.
    i_req_addr  = ~addr;
    i_req_wdata = ~wdata;
    i_req_be    = ~be;
    i_req_we    = ~we;
  endtask

  // Run one full transaction. The slave acks in stb cycle waits+1. The CPU
  // holds i_rsp_ready low for 'hold' response cycles and meanwhile tries to
  // issue another request.
  task automatic do_txn(input logic [AW-1:0] addr, input logic we,
                        input logic [DW-1:0] wdata, input logic [DW/8-1:0] be,
                        input int waits, input logic [DW-1:0] ack_dat,
                        input int hold);
    logic [DW-1:0] exp_rd;
    exp_rd = we ? '0 : ack_dat;
    start_req(addr, we, wdata, be);
    for (int w = 0; w <= waits; w++) begin
      i_wbm_ack = (w == waits);
      i_wbm_dat = (w == waits) ? ack_dat : 32'hDEAD_BEEF;
      if (w == waits) push_exp(exp_rd, 1'b0);
      @(negedge clk);
      check("bus_cyc_stb", {o_wbm_cyc, o_wbm_stb}, 2'b11);
      check("bus_adr",     o_wbm_adr, addr);
      check("bus_dat",     o_wbm_dat, wdata);
      check("bus_sel",     o_wbm_sel, be);
      check("bus_we",      o_wbm_we,  we);
      check("bus_no_rdy",  {o_req_ready, o_rsp_valid}, 2'b00);
      @(posedge clk); #1;
    end
    i_wbm_ack   = 1'b0;
    i_wbm_dat   = 32'hDEAD_BEEF;
    i_rsp_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      i_req_valid = 1'b1;
      i_req_addr  = 32'h1111_1110;
      @(negedge clk);
      check("hold_rsp_valid", o_rsp_valid, 1'b1);
      check("hold_rsp_rdata", o_rsp_rdata, exp_rd);
      check("hold_rsp_err",   o_rsp_err,   1'b0);
      check("hold_req_ready", o_req_ready, 1'b0);
      check("hold_no_cyc",    o_wbm_cyc,   1'b0);
      @(posedge clk); #1;
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    check("resp_valid",  o_rsp_valid, 1'b1);
    check("resp_no_stb", {o_wbm_cyc, o_wbm_stb}, 2'b00);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_req_we    = 1'b0;
    i_req_wdata = '0;
    i_req_be    = '0;
    i_rsp_ready = 1'b1;
    i_wbm_dat   = '0;
    i_wbm_ack   = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", o_req_ready, 1'b0);
    check("rst_wbm_ctl",   {o_wbm_cyc, o_wbm_stb, o_wbm_we}, 3'b000);
    check("rst_wbm_adr",   o_wbm_adr, 32'h0);
    check("rst_wbm_dat",   o_wbm_dat, 32'h0);
    check("rst_wbm_sel",   o_wbm_sel, 4'h0);
    check("rst_rsp",       {o_rsp_valid, o_rsp_err}, 2'b00);
    check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: zero-wait read
    do_txn(32'h8000_0010, 1'b0, 32'h0, 4'hF, 0, 32'hCAFE_F00D, 0);

    // Ack outside BUS must not disturb anything
    i_wbm_ack = 1'b1;
    i_wbm_dat = 32'h0BAD_0BAD;
    @(negedge clk);
    check("idle_ack_rdata", o_rsp_rdata, 32'hCAFE_F00D);
    check("idle_ack_ctl",   {o_rsp_valid, o_wbm_cyc, o_wbm_stb}, 3'b000);
    @(posedge clk); #1;
    i_wbm_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_after", {o_rsp_valid, o_wbm_cyc}, 2'b00);
    @(posedge clk); #1;

    // 2: write with 3 wait states (4 stb cycles)
    do_txn(32'h0000_0404, 1'b1, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_FFFF, 0);

    // 3: response backpressure for 5 cycles
    do_txn(32'h4000_0020, 1'b0, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 5);

    // 4: no ack at all
    start_req(32'hDEAD_0000, 1'b0, 32'h0, 4'hF);
    n = 0;
`ifdef WB_TIMEOUT_EN
    push_exp(32'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!o_wbm_stb) break;
      n++;
    end
    check("tmo_stb_cycles", n, 255);
    check("tmo_rsp",        {o_rsp_valid, o_rsp_err, o_wbm_cyc}, 3'b110);
    check("tmo_rdata",      o_rsp_rdata, 32'h0);
    @(posedge clk); #1;
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!o_wbm_stb) break;
      n++;
    end
    check("no_tmo_stb_held", n, 300);
    check("no_tmo_err",      o_rsp_err, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("no_tmo_recover", {o_wbm_cyc, o_wbm_stb, o_rsp_valid}, 3'b000);
    @(posedge clk); #1;
`endif

    // 5: ack on the 255th stb cycle (the expiry cycle) -> normal completion
    do_txn(32'hDEAD_0004, 1'b0, 32'h0, 4'hF, 254, 32'h5A5A_A5A5, 0);

    // 6: reset during BUS discards the cycle, and a spurious ack afterwards
    //    is ignored.
    start_req(32'h2000_0000, 1'b0, 32'h0, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    check("rstbus_req_ready", o_req_ready, 1'b0);
    @(posedge clk); #1;
    rst       = 1'b0;
    i_wbm_ack = 1'b1;
    i_wbm_dat = 32'hBAD0_BAD0;
    @(negedge clk);
    check("rstbus_cyc_stb", {o_wbm_cyc, o_wbm_stb}, 2'b00);
    check("rstbus_no_rsp",  o_rsp_valid, 1'b0);
    check("rstbus_ready",   o_req_ready, 1'b1);
    @(posedge clk); #1;
    i_wbm_ack = 1'b0;
    @(negedge clk);
    check("rstbus_no_rsp2", {o_rsp_valid, o_wbm_cyc}, 2'b00);
    @(posedge clk); #1;
    do_txn(32'h2000_0008, 1'b0, 32'h0, 4'b1100, 2, 32'h1357_9BDF, 0);

    repeat (2) @(posedge clk);
    check("sb_queue_empty", exp_q.size(), 0);
    check("sb_rsp_count",   n_popped, n_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
